// File: rtl/upstream_cxl_tx.sv
// upstream_cxl_tx: buffers cancel records from the matching logic in a
// small FIFO and offers them one at a time to the downstream accumulator
// over a valid/ack handshake. On an ack timeout the offer is retried, and
// after a bounded number of retries the record is dropped. Saturating
// delivered/dropped counters are kept for status readout.
module upstream_cxl_tx #(
    parameter int ID_WIDTH   = 5,
    parameter int AMT_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 8,
    parameter int MAX_RETRY  = 2
) (
    input  logic                 clk,
    input  logic                 HRESETn,
    input  logic                 req_valid,
    input  logic [ID_WIDTH-1:0]  req_client_id,
    input  logic [AMT_WIDTH-1:0] req_amount,
    output logic                 req_ready,
    output logic                 tx_valid,
    output logic [ID_WIDTH-1:0]  tx_client_id,
    output logic [AMT_WIDTH-1:0] tx_amount,
    input  logic                 tx_ack,
    output logic                 busy,
    output logic [15:0]          sent_count,
    output logic [15:0]          drop_count
);

    // Pointer, occupancy, timer and retry widths. The retry counter must
    // be able to hold MAX_RETRY itself, and is kept at least 1 bit wide.
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int TIMER_W = $clog2(TIMEOUT);
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int REC_W   = ID_WIDTH + AMT_WIDTH;

    localparam logic [CNT_W-1:0]   FULL_LEVEL = CNT_W'(FIFO_DEPTH);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY);
    localparam logic [15:0]        CNT_SAT    = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        RETRY    = 2'd2,
        GAP      = 2'd3
    } state_t;

    // Registered state
    state_t                 state_q,        state_d;
    logic [REC_W-1:0]       mem_q [FIFO_DEPTH];
    logic [REC_W-1:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q,       wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q,       rd_ptr_d;
    logic [CNT_W-1:0]       count_q,        count_d;
    logic [TIMER_W-1:0]     timer_q,        timer_d;
    logic [RETRY_W-1:0]     retry_q,        retry_d;
    logic                   tx_valid_q,     tx_valid_d;
    logic [ID_WIDTH-1:0]    tx_client_id_q, tx_client_id_d;
    logic [AMT_WIDTH-1:0]   tx_amount_q,    tx_amount_d;
    logic [15:0]            sent_q,         sent_d;
    logic [15:0]            drop_q,         drop_d;

    // Handshake and FIFO control
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;
    logic [REC_W-1:0]       head_rec;

    // FIFO status and the push/pop decisions. Zero-amount requests are
    // accepted on the handshake but never written, so they cost nothing
    // downstream. A pop only happens on the IDLE load cycle.
    always_comb begin
        fifo_full  = (count_q == FULL_LEVEL);
        fifo_empty = (count_q == '0);
        push       = req_valid && !fifo_full && (req_amount != '0);
        pop        = (state_q == IDLE) && !fifo_empty;
        head_rec   = mem_q[rd_ptr_q];
    end

    // FIFO storage, pointers and occupancy next-state. Pointers wrap
    // naturally because the depth is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {req_client_id, req_amount};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Transmit FSM next-state: load from the FIFO in IDLE, wait for the
    // ack with a timeout, retry a bounded number of times, and always
    // insert one idle GAP cycle so each record is a separate write.
    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        retry_d        = retry_q;
        tx_valid_d     = tx_valid_q;
        tx_client_id_d = tx_client_id_q;
        tx_amount_d    = tx_amount_q;
        sent_d         = sent_q;
        drop_d         = drop_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    tx_client_id_d = head_rec[REC_W-1:AMT_WIDTH];
                    tx_amount_d    = head_rec[AMT_WIDTH-1:0];
                    tx_valid_d     = 1'b1;
                    timer_d        = '0;
                    retry_d        = '0;
                    state_d        = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (tx_ack) begin
                    // An ack on the timeout cycle still counts as delivered.
                    if (sent_q != CNT_SAT) begin
                        sent_d = sent_q + 16'd1;
                    end
                    tx_valid_d = 1'b0;
                    state_d    = GAP;
                end else if (timer_q == TIMER_LAST) begin
                    tx_valid_d = 1'b0;
                    if (retry_q < RETRY_LAST) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = RETRY;
                    end else begin
                        if (drop_q != CNT_SAT) begin
                            drop_d = drop_q + 16'd1;
                        end
                        state_d = GAP;
                    end
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            RETRY: begin
                tx_valid_d = 1'b1;
                timer_d    = '0;
                state_d    = WAIT_ACK;
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                tx_valid_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    // State registers; reset discards any buffered or in-flight record.
    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q        <= IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            timer_q        <= '0;
            retry_q        <= '0;
            tx_valid_q     <= 1'b0;
            tx_client_id_q <= '0;
            tx_amount_q    <= '0;
            sent_q         <= '0;
            drop_q         <= '0;
        end else begin
            state_q        <= state_d;
            mem_q          <= mem_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            timer_q        <= timer_d;
            retry_q        <= retry_d;
            tx_valid_q     <= tx_valid_d;
            tx_client_id_q <= tx_client_id_d;
            tx_amount_q    <= tx_amount_d;
            sent_q         <= sent_d;
            drop_q         <= drop_d;
        end
    end

    // Output drive: ready and busy follow occupancy/state directly.
    always_comb begin
        req_ready    = !fifo_full;
        busy         = (state_q != IDLE) || !fifo_empty;
        tx_valid     = tx_valid_q;
        tx_client_id = tx_client_id_q;
        tx_amount    = tx_amount_q;
        sent_count   = sent_q;
        drop_count   = drop_q;
    end

endmodule

// File: tb/tb_upstream_cxl_tx.sv
// Directed bench for upstream_cxl_tx: reset values, single delivery,
// burst with back-pressure, timeout/drop, ack on the timeout cycle,
// zero-amount and stray acks, and reset mid-flight.
module tb_upstream_cxl_tx;

    logic        clk;
    logic        HRESETn;
    logic        req_valid;
    logic [4:0]  req_client_id;
    logic [15:0] req_amount;
    logic        req_ready;
    logic        tx_valid;
    logic [4:0]  tx_client_id;
    logic [15:0] tx_amount;
    logic        tx_ack;
    logic        busy;
    logic [15:0] sent_count;
    logic [15:0] drop_count;

    int checks;
    int failures;
    int cycle;
    int n;
    int last_offer;
    logic seen_valid;

    upstream_cxl_tx #(
        .ID_WIDTH  (5),
        .AMT_WIDTH (16),
        .FIFO_DEPTH(4),
        .TIMEOUT   (8),
        .MAX_RETRY (2)
    ) dut (
        .clk          (clk),
        .HRESETn      (HRESETn),
        .req_valid    (req_valid),
        .req_client_id(req_client_id),
        .req_amount   (req_amount),
        .req_ready    (req_ready),
        .tx_valid     (tx_valid),
        .tx_client_id (tx_client_id),
        .tx_amount    (tx_amount),
        .tx_ack       (tx_ack),
        .busy         (busy),
        .sent_count   (sent_count),
        .drop_count   (drop_count)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog");
    end

    // Advance one clock; inputs are driven and outputs sampled 1 unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Hold a request for one edge, then drop req_valid
    task automatic applyStimulus(input logic [4:0] id, input logic [15:0] amt);
        req_valid     = 1'b1;
        req_client_id = id;
        req_amount    = amt;
        tick();
        req_valid     = 1'b0;
    endtask

    task automatic doReset();
        HRESETn = 1'b0;
        tick();
        tick();
        HRESETn = 1'b1;
        tick();
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        cycle         = 0;
        HRESETn       = 1'b1;
        req_valid     = 1'b0;
        req_client_id = '0;
        req_amount    = '0;
        tx_ack        = 1'b0;

        // ---- Reset asserted asynchronously mid-cycle ----
        #12;
        HRESETn = 1'b0;
        #1;
        checkOutput("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        checkOutput("rst_tx_id",    {27'd0, tx_client_id}, 32'd0);
        checkOutput("rst_tx_amt",   {16'd0, tx_amount}, 32'd0);
        checkOutput("rst_busy",     {31'd0, busy}, 32'd0);
        checkOutput("rst_sent",     {16'd0, sent_count}, 32'd0);
        checkOutput("rst_drop",     {16'd0, drop_count}, 32'd0);
        checkOutput("rst_ready",    {31'd0, req_ready}, 32'd1);
        tick();
        tick();
        HRESETn = 1'b1;
        tick();

        // ---- Single record (3,10), ack on first WAIT_ACK cycle ----
        applyStimulus(5'd3, 16'd10);
        checkOutput("single_not_yet", {31'd0, tx_valid}, 32'd0);
        checkOutput("single_busy",    {31'd0, busy}, 32'd1);
        tick();
        checkOutput("single_valid", {31'd0, tx_valid}, 32'd1);
        checkOutput("single_id",    {27'd0, tx_client_id}, 32'd3);
        checkOutput("single_amt",   {16'd0, tx_amount}, 32'd10);
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        checkOutput("single_dropped_valid", {31'd0, tx_valid}, 32'd0);
        checkOutput("single_sent", {16'd0, sent_count}, 32'd1);
        checkOutput("single_id_held", {27'd0, tx_client_id}, 32'd3);
        tick();
        checkOutput("single_idle_busy", {31'd0, busy}, 32'd0);

        // ---- Burst of 5 with acks low; back-pressure after 4+1 ----
        doReset();
        for (int i = 0; i < 5; i++) begin
            req_valid     = 1'b1;
            req_client_id = 5'(i + 1);
            req_amount    = 16'(100 + i);
            tick();
            checkOutput($sformatf("burst_ready_%0d", i), {31'd0, req_ready}, (i < 4) ? 32'd1 : 32'd0);
        end
        req_valid = 1'b0;
        last_offer = 0;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (!tx_valid && n < 20) begin
                tick();
                n++;
            end
            checkOutput($sformatf("burst_offer_%0d", k), {31'd0, tx_valid}, 32'd1);
            checkOutput($sformatf("burst_id_%0d", k),  {27'd0, tx_client_id}, 32'(k + 1));
            checkOutput($sformatf("burst_amt_%0d", k), {16'd0, tx_amount}, 32'(100 + k));
            if (k > 0) begin
                checkOutput($sformatf("burst_spacing_%0d", k), 32'(cycle - last_offer), 32'd3);
            end
            last_offer = cycle;
            tx_ack = 1'b1;
            tick();
            tx_ack = 1'b0;
        end
        checkOutput("burst_sent", {16'd0, sent_count}, 32'd5);
        checkOutput("burst_ready_end", {31'd0, req_ready}, 32'd1);

        // ---- Timeout and drop: 3 attempts of 8 cycles, 1-cycle gaps ----
        doReset();
        applyStimulus(5'd7, 16'd55);
        tick();
        for (int a = 0; a < 3; a++) begin
            n = 0;
            while (tx_valid && n < 40) begin
                n++;
                tick();
            end
            checkOutput($sformatf("to_attempt_len_%0d", a), 32'(n), 32'd8);
            if (a < 2) begin
                checkOutput($sformatf("to_retry_gap_%0d", a), {31'd0, tx_valid}, 32'd0);
                tick();
                checkOutput($sformatf("to_reoffer_%0d", a), {31'd0, tx_valid}, 32'd1);
            end
        end
        checkOutput("to_drop", {16'd0, drop_count}, 32'd1);
        checkOutput("to_sent", {16'd0, sent_count}, 32'd0);
        tick();
        checkOutput("to_busy_after", {31'd0, busy}, 32'd0);

        // ---- Ack on the 8th WAIT_ACK cycle of the second attempt ----
        doReset();
        applyStimulus(5'd9, 16'd77);
        tick();
        n = 0;
        while (tx_valid && n < 40) begin
            n++;
            tick();
        end
        tick();
        checkOutput("ackto_second_offer", {31'd0, tx_valid}, 32'd1);
        for (int c = 0; c < 7; c++) tick();
        checkOutput("ackto_still_valid", {31'd0, tx_valid}, 32'd1);
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        checkOutput("ackto_sent", {16'd0, sent_count}, 32'd1);
        checkOutput("ackto_drop", {16'd0, drop_count}, 32'd0);
        seen_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            seen_valid = seen_valid | tx_valid;
        end
        checkOutput("ackto_no_third", {31'd0, seen_valid}, 32'd0);
        checkOutput("ackto_busy", {31'd0, busy}, 32'd0);

        // ---- Zero amount and stray acks ----
        doReset();
        applyStimulus(5'd4, 16'd0);
        checkOutput("zero_busy", {31'd0, busy}, 32'd0);
        checkOutput("zero_ready", {31'd0, req_ready}, 32'd1);
        seen_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            seen_valid = seen_valid | tx_valid | busy;
        end
        checkOutput("zero_never_offered", {31'd0, seen_valid}, 32'd0);
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        checkOutput("stray_idle_sent", {16'd0, sent_count}, 32'd0);
        checkOutput("stray_idle_drop", {16'd0, drop_count}, 32'd0);
        applyStimulus(5'd5, 16'd20);
        tick();
        checkOutput("stray_offer", {31'd0, tx_valid}, 32'd1);
        tx_ack = 1'b1;
        tick();
        checkOutput("stray_sent_once", {16'd0, sent_count}, 32'd1);
        tick();
        tx_ack = 1'b0;
        checkOutput("stray_gap_sent", {16'd0, sent_count}, 32'd1);
        checkOutput("stray_gap_drop", {16'd0, drop_count}, 32'd0);

        // ---- Reset in WAIT_ACK with 2 records buffered ----
        doReset();
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_client_id = 5'(i + 1);
            req_amount    = 16'(11 + i);
            tick();
        end
        req_valid = 1'b0;
        checkOutput("mid_valid_before", {31'd0, tx_valid}, 32'd1);
        #2;
        HRESETn = 1'b0;
        #1;
        checkOutput("mid_valid_rst", {31'd0, tx_valid}, 32'd0);
        checkOutput("mid_ready_rst", {31'd0, req_ready}, 32'd1);
        tick();
        HRESETn = 1'b1;
        seen_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            seen_valid = seen_valid | tx_valid | busy;
        end
        checkOutput("mid_quiet_after", {31'd0, seen_valid}, 32'd0);
        checkOutput("mid_sent", {16'd0, sent_count}, 32'd0);
        checkOutput("mid_drop", {16'd0, drop_count}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
